// File: rtl/brisc_pkg.sv
// Shared brisc types: decode control bundle, operand/ALU selectors and issue-stage FSM states.
package brisc_pkg;

   // RV32 major opcodes handled by the brisc subset; END reuses the SYSTEM opcode
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_END    = 7'b1110011;

   localparam logic [6:0] F7_BASE   = 7'b0000000;
   localparam logic [6:0] F7_ALT    = 7'b0100000;
   localparam logic [6:0] F7_MULDIV = 7'b0000001;

   typedef enum logic [2:0] {IMM_I, IMM_S, IMM_B, IMM_U, IMM_J} imm_src_e;
   typedef enum logic [1:0] {RES_ALU, RES_MEM, RES_PC4} result_src_e;
   typedef enum logic {SRC1_RS1, SRC1_PC} alu_src1_e;
   typedef enum logic {SRC2_RS2, SRC2_IMM} alu_src2_e;
   typedef enum logic [2:0] {ALU_ADD, ALU_SUB, ALU_MUL, ALU_OR, ALU_AND} alu_ctrl_e;
   typedef enum logic {SIZE_WORD, SIZE_BYTE} data_size_e;
   typedef enum logic {NO_XCPT, UNDEF_INSTR} xcpt_e;

   typedef enum logic [1:0] {RUN, MUL_BUSY, HALT} dec_state_e;

   typedef struct packed {
      logic        reg_write;
      imm_src_e    imm_src;
      result_src_e result_src;
      alu_src1_e   alu_src1;
      alu_src2_e   alu_src2;
      alu_ctrl_e   alu_ctrl;
      data_size_e  data_size;
      logic        mem_write;
      logic        is_branch;
      logic        is_jump;
   } dec_ctrl_t;

endpackage

// File: rtl/decode_issue_scoreboard.sv
// Pending-write scoreboard: one bit per architectural register, set on issue, cleared by writeback.
module scoreboard
   import brisc_pkg::*;
#(
   parameter int unsigned NUM_REGS     = 32,
   parameter int unsigned NUM_WB_PORTS = 2,
   localparam int unsigned RW          = $clog2(NUM_REGS)
) (
   input  logic                             clk,
   input  logic                             reset,
   input  logic                             set_en,
   input  logic [RW-1:0]                    set_idx,
   input  logic [NUM_WB_PORTS-1:0]          wb_valid,
   input  logic [NUM_WB_PORTS-1:0][RW-1:0]  wb_rd,
   input  logic                             clear_all,
   output logic [NUM_REGS-1:0]              pending
);

   logic [NUM_REGS-1:0] pending_d, pending_q;

   // Clears first so a same-cycle issue to the same register wins; x0 never pends
   always_comb begin
      pending_d = pending_q;
      if (clear_all) begin
         pending_d = '0;
      end else begin
         for (int unsigned i = 0; i < NUM_WB_PORTS; i++) begin
            if (wb_valid[i]) pending_d[wb_rd[i]] = 1'b0;
         end
         if (set_en) pending_d[set_idx] = 1'b1;
      end
      pending_d[0] = 1'b0;
   end

   // Pending vector register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) pending_q <= '0;
      else       pending_q <= pending_d;
   end

   assign pending = pending_q;

endmodule

// File: rtl/decode_issue.sv
// brisc decode-and-issue stage: decodes, checks RAW/WAW against the scoreboard, serialises MUL,
// and halts after END or an undefined instruction until flushed.
module decode_issue
   import brisc_pkg::*;
#(
   parameter int unsigned XLEN         = 32,
   parameter int unsigned NUM_REGS     = 32,
   parameter int unsigned NUM_WB_PORTS = 2,
   parameter int unsigned MUL_LATENCY  = 4,
   localparam int unsigned RW          = $clog2(NUM_REGS)
) (
   input  logic                             clk,
   input  logic                             reset,
   input  logic                             in_valid,
   output logic                             in_ready,
   input  logic [31:0]                      in_instr,
   input  logic [XLEN-1:0]                  in_pc,
   output logic                             out_valid,
   input  logic                             out_ready,
   output dec_ctrl_t                        out_ctrl,
   output logic [XLEN-1:0]                  out_pc,
   output logic [RW-1:0]                    out_rs1,
   output logic [RW-1:0]                    out_rs2,
   output logic [RW-1:0]                    out_rd,
   output xcpt_e                            out_xcpt,
   input  logic [NUM_WB_PORTS-1:0]          wb_valid,
   input  logic [NUM_WB_PORTS-1:0][RW-1:0]  wb_rd,
   input  logic                             flush,
   output logic                             halted
);

   localparam int unsigned CW = (MUL_LATENCY > 1) ? $clog2(MUL_LATENCY) : 1;

   logic [6:0]    opcode, funct7;
   logic [2:0]    funct3;
   logic [RW-1:0] rs1, rs2, rd;
   dec_ctrl_t     ctrl;
   logic          undef, rs1_used, rs2_used, is_mul, is_end;
   logic          hazard, issue;
   logic [NUM_REGS-1:0] pending;

   dec_state_e    state_d, state_q;
   logic [CW-1:0] cnt_d, cnt_q;

   logic          out_valid_d, out_valid_q;
   dec_ctrl_t     out_ctrl_q;
   logic [XLEN-1:0] out_pc_q;
   logic [RW-1:0] out_rs1_q, out_rs2_q, out_rd_q;
   xcpt_e         out_xcpt_q;

   assign opcode = in_instr[6:0];
   assign funct3 = in_instr[14:12];
   assign funct7 = in_instr[31:25];
   assign rd     = in_instr[7 +: RW];
   assign rs1    = in_instr[15 +: RW];
   assign rs2    = in_instr[20 +: RW];

   // Decode table; operand-use flags follow the opcode, undefined encodings carry a null ctrl
   always_comb begin
      ctrl     = '0;
      undef    = 1'b0;
      rs1_used = 1'b0;
      rs2_used = 1'b0;
      is_mul   = 1'b0;
      is_end   = 1'b0;
      case (opcode)
         OPC_LOAD: begin
            rs1_used            = 1'b1;
            ctrl.reg_write      = 1'b1;
            ctrl.result_src     = RES_MEM;
            ctrl.alu_src2       = SRC2_IMM;
            case (funct3)
               3'b000:  ctrl.data_size = SIZE_BYTE;
               3'b010:  ctrl.data_size = SIZE_WORD;
               default: undef = 1'b1;
            endcase
         end
         OPC_STORE: begin
            rs1_used       = 1'b1;
            rs2_used       = 1'b1;
            ctrl.imm_src   = IMM_S;
            ctrl.alu_src2  = SRC2_IMM;
            ctrl.mem_write = 1'b1;
            case (funct3)
               3'b000:  ctrl.data_size = SIZE_BYTE;
               3'b010:  ctrl.data_size = SIZE_WORD;
               default: undef = 1'b1;
            endcase
         end
         OPC_OP: begin
            rs1_used       = 1'b1;
            rs2_used       = 1'b1;
            ctrl.reg_write = 1'b1;
            case ({funct7, funct3})
               {F7_BASE, 3'b000}:   ctrl.alu_ctrl = ALU_ADD;
               {F7_ALT, 3'b000}:    ctrl.alu_ctrl = ALU_SUB;
               {F7_MULDIV, 3'b000}: begin
                  ctrl.alu_ctrl = ALU_MUL;
                  is_mul        = 1'b1;
               end
               {F7_BASE, 3'b110}:   ctrl.alu_ctrl = ALU_OR;
               {F7_BASE, 3'b111}:   ctrl.alu_ctrl = ALU_AND;
               default:             undef = 1'b1;
            endcase
         end
         OPC_OP_IMM: begin
            rs1_used       = 1'b1;
            ctrl.reg_write = 1'b1;
            ctrl.alu_src2  = SRC2_IMM;
            case (funct3)
               3'b000:  ctrl.alu_ctrl = ALU_ADD;
               3'b110:  ctrl.alu_ctrl = ALU_OR;
               3'b111:  ctrl.alu_ctrl = ALU_AND;
               default: undef = 1'b1;
            endcase
         end
         OPC_AUIPC: begin
            ctrl.reg_write = 1'b1;
            ctrl.imm_src   = IMM_U;
            ctrl.alu_src1  = SRC1_PC;
            ctrl.alu_src2  = SRC2_IMM;
         end
         OPC_BRANCH: begin
            rs1_used       = 1'b1;
            rs2_used       = 1'b1;
            ctrl.imm_src   = IMM_B;
            ctrl.alu_ctrl  = ALU_SUB;
            ctrl.is_branch = 1'b1;
            if (funct3 != 3'b000) undef = 1'b1;
         end
         OPC_JAL: begin
            ctrl.reg_write  = 1'b1;
            ctrl.imm_src    = IMM_J;
            ctrl.result_src = RES_PC4;
            ctrl.alu_src1   = SRC1_PC;
            ctrl.alu_src2   = SRC2_IMM;
            ctrl.is_jump    = 1'b1;
         end
         OPC_END: is_end = 1'b1;
         default: undef = 1'b1;
      endcase
      if (undef) ctrl = '0;
   end

   assign hazard = (rs1_used & pending[rs1]) | (rs2_used & pending[rs2]) |
                   (ctrl.reg_write & pending[rd]);
   assign in_ready = (state_q == RUN) & ~hazard & (~out_valid_q | out_ready) & ~flush;
   assign issue    = in_valid & in_ready;

   scoreboard #(
      .NUM_REGS     (NUM_REGS),
      .NUM_WB_PORTS (NUM_WB_PORTS)
   ) u_sb (
      .clk       (clk),
      .reset     (reset),
      .set_en    (issue & ctrl.reg_write & (rd != '0)),
      .set_idx   (rd),
      .wb_valid  (wb_valid),
      .wb_rd     (wb_rd),
      .clear_all (flush),
      .pending   (pending)
   );

   // Issue FSM next state: MUL busy countdown, sticky HALT, flush restarts in RUN
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      if (flush) begin
         state_d = RUN;
         cnt_d   = '0;
      end else begin
         case (state_q)
            RUN: begin
               if (issue) begin
                  if (is_end | undef) begin
                     state_d = HALT;
                  end else if (is_mul) begin
                     state_d = MUL_BUSY;
                     cnt_d   = CW'(MUL_LATENCY - 1);
                  end
               end
            end
            MUL_BUSY: begin
               if (cnt_q == '0) state_d = RUN;
               else             cnt_d   = cnt_q - CW'(1);
            end
            HALT:    state_d = HALT;
            default: state_d = RUN;
         endcase
      end
   end

   // FSM state and MUL counter registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= RUN;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   assign out_valid_d = flush ? 1'b0 : (issue ? 1'b1 : (out_ready ? 1'b0 : out_valid_q));

   // Output bundle register; payload only loads on issue so it holds under backpressure
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         out_valid_q <= 1'b0;
         out_ctrl_q  <= '0;
         out_pc_q    <= '0;
         out_rs1_q   <= '0;
         out_rs2_q   <= '0;
         out_rd_q    <= '0;
         out_xcpt_q  <= NO_XCPT;
      end else begin
         out_valid_q <= out_valid_d;
         if (issue) begin
            out_ctrl_q <= ctrl;
            out_pc_q   <= in_pc;
            out_rs1_q  <= rs1;
            out_rs2_q  <= rs2;
            out_rd_q   <= rd;
            out_xcpt_q <= undef ? UNDEF_INSTR : NO_XCPT;
         end
      end
   end

   assign out_valid = out_valid_q;
   assign out_ctrl  = out_ctrl_q;
   assign out_pc    = out_pc_q;
   assign out_rs1   = out_rs1_q;
   assign out_rs2   = out_rs2_q;
   assign out_rd    = out_rd_q;
   assign out_xcpt  = out_xcpt_q;
   assign halted    = (state_q == HALT);

endmodule

// File: tb/tb_decode_issue.sv
// Directed bench for decode_issue: decode table vectors plus hazard, MUL, halt, backpressure and
// reset sequences.
module tb_decode_issue;
   import brisc_pkg::*;

   localparam logic [6:0] T_LOAD = 7'b0000011, T_STORE = 7'b0100011, T_OP = 7'b0110011;
   localparam logic [6:0] T_OPI = 7'b0010011, T_AUIPC = 7'b0010111, T_BR = 7'b1100011;
   localparam logic [6:0] T_JAL = 7'b1101111, T_END = 7'b1110011;
   localparam int NV = 21;

   logic            clk = 1'b0;
   logic            reset;
   logic            in_valid, in_ready, out_valid, out_ready, flush, halted;
   logic [31:0]     in_instr, in_pc, out_pc;
   dec_ctrl_t       out_ctrl;
   logic [4:0]      out_rs1, out_rs2, out_rd;
   xcpt_e           out_xcpt;
   logic [1:0]      wb_valid;
   logic [1:0][4:0] wb_rd;

   int n_cmp = 0;
   int n_fail = 0;

   typedef struct {
      logic [31:0] instr;
      logic [31:0] pc;
      dec_ctrl_t   ctrl;
      xcpt_e       xcpt;
      logic        halt;
      logic        busy;
   } vec_t;
   vec_t vecs[NV];

   always #5 clk = ~clk;

   decode_issue dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_instr  (in_instr),
      .in_pc     (in_pc),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_ctrl  (out_ctrl),
      .out_pc    (out_pc),
      .out_rs1   (out_rs1),
      .out_rs2   (out_rs2),
      .out_rd    (out_rd),
      .out_xcpt  (out_xcpt),
      .wb_valid  (wb_valid),
      .wb_rd     (wb_rd),
      .flush     (flush),
      .halted    (halted)
   );

   function automatic logic [31:0] enc(input logic [6:0] f7, input logic [4:0] r2,
                                       input logic [4:0] r1, input logic [2:0] f3,
                                       input logic [4:0] d, input logic [6:0] op);
      return {f7, r2, r1, f3, d, op};
   endfunction

   function automatic dec_ctrl_t mk(input logic rw, input imm_src_e imm, input result_src_e res,
                                    input alu_src1_e s1, input alu_src2_e s2,
                                    input alu_ctrl_e alu, input data_size_e sz,
                                    input logic mw, input logic br, input logic jp);
      dec_ctrl_t c;
      c.reg_write = rw;  c.imm_src = imm;  c.result_src = res;  c.alu_src1 = s1;
      c.alu_src2 = s2;   c.alu_ctrl = alu; c.data_size = sz;    c.mem_write = mw;
      c.is_branch = br;  c.is_jump = jp;
      return c;
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_flush();
      in_valid = 1'b0;
      flush    = 1'b1;
      step();
      flush    = 1'b0;
   endtask

   initial begin
      dec_ctrl_t z;
      z = '0;
      vecs[0]  = '{enc(7'h00, 5'd2, 5'd1, 3'b000, 5'd3, T_OP), 32'h1000,
                   mk(1'b1, IMM_I, RES_ALU, SRC1_RS1, SRC2_RS2, ALU_ADD, SIZE_WORD, 1'b0, 1'b0, 1'b0),
                   NO_XCPT, 1'b0, 1'b0};
      vecs[1]  = '{enc(7'h20, 5'd6, 5'd5, 3'b000, 5'd4, T_OP), 32'h1004,
                   mk(1'b1, IMM_I, RES_ALU, SRC1_RS1, SRC2_RS2, ALU_SUB, SIZE_WORD, 1'b0, 1'b0, 1'b0),
                   NO_XCPT, 1'b0, 1'b0};
      vecs[2]  = '{enc(7'h01, 5'd2, 5'd1, 3'b000, 5'd7, T_OP), 32'h1008,
                   mk(1'b1, IMM_I, RES_ALU, SRC1_RS1, SRC2_RS2, ALU_MUL, SIZE_WORD, 1'b0, 1'b0, 1'b0),
                   NO_XCPT, 1'b0, 1'b1};
      vecs[3]  = '{enc(7'h00, 5'd2, 5'd1, 3'b110, 5'd8, T_OP), 32'h100C,
                   mk(1'b1, IMM_I, RES_ALU, SRC1_RS1, SRC2_RS2, ALU_OR, SIZE_WORD, 1'b0, 1'b0, 1'b0),
                   NO_XCPT, 1'b0, 1'b0};
      vecs[4]  = '{enc(7'h00, 5'd4, 5'd3, 3'b111, 5'd9, T_OP), 32'h1010,
                   mk(1'b1, IMM_I, RES_ALU, SRC1_RS1, SRC2_RS2, ALU_AND, SIZE_WORD, 1'b0, 1'b0, 1'b0),
                   NO_XCPT, 1'b0, 1'b0};
      vecs[5]  = '{enc(7'h00, 5'd1, 5'd0, 3'b000, 5'd5, T_OPI), 32'h1014,
                   mk(1'b1, IMM_I, RES_ALU, SRC1_RS1, SRC2_IMM, ALU_ADD, SIZE_WORD, 1'b0, 1'b0, 1'b0),
                   NO_XCPT, 1'b0, 1'b0};
      vecs[6]  = '{enc(7'h07, 5'h10, 5'd2, 3'b110, 5'd6, T_OPI), 32'h1018,
                   mk(1'b1, IMM_I, RES_ALU, SRC1_RS1, SRC2_IMM, ALU_OR, SIZE_WORD, 1'b0, 1'b0, 1'b0),
                   NO_XCPT, 1'b0, 1'b0};
      vecs[7]  = '{enc(7'h7F, 5'h1F, 5'd3, 3'b111, 5'd7, T_OPI), 32'h101C,
                   mk(1'b1, IMM_I, RES_ALU, SRC1_RS1, SRC2_IMM, ALU_AND, SIZE_WORD, 1'b0, 1'b0, 1'b0),
                   NO_XCPT, 1'b0, 1'b0};
      vecs[8]  = '{enc(7'h00, 5'd4, 5'd1, 3'b000, 5'd9, T_LOAD), 32'h1020,
                   mk(1'b1, IMM_I, RES_MEM, SRC1_RS1, SRC2_IMM, ALU_ADD, SIZE_BYTE, 1'b0, 1'b0, 1'b0),
                   NO_XCPT, 1'b0, 1'b0};
      vecs[9]  = '{enc(7'h00, 5'd8, 5'd2, 3'b010, 5'd10, T_LOAD), 32'h1024,
                   mk(1'b1, IMM_I, RES_MEM, SRC1_RS1, SRC2_IMM, ALU_ADD, SIZE_WORD, 1'b0, 1'b0, 1'b0),
                   NO_XCPT, 1'b0, 1'b0};
      vecs[10] = '{enc(7'h00, 5'd3, 5'd1, 3'b000, 5'd1, T_STORE), 32'h1028,
                   mk(1'b0, IMM_S, RES_ALU, SRC1_RS1, SRC2_IMM, ALU_ADD, SIZE_BYTE, 1'b1, 1'b0, 1'b0),
                   NO_XCPT, 1'b0, 1'b0};
      vecs[11] = '{enc(7'h00, 5'd4, 5'd2, 3'b010, 5'd4, T_STORE), 32'h102C,
                   mk(1'b0, IMM_S, RES_ALU, SRC1_RS1, SRC2_IMM, ALU_ADD, SIZE_WORD, 1'b1, 1'b0, 1'b0),
                   NO_XCPT, 1'b0, 1'b0};
      vecs[12] = '{enc(7'h09, 5'h03, 5'h05, 3'b001, 5'd11, T_AUIPC), 32'h1030,
                   mk(1'b1, IMM_U, RES_ALU, SRC1_PC, SRC2_IMM, ALU_ADD, SIZE_WORD, 1'b0, 1'b0, 1'b0),
                   NO_XCPT, 1'b0, 1'b0};
      vecs[13] = '{enc(7'h00, 5'd2, 5'd1, 3'b000, 5'd8, T_BR), 32'h1034,
                   mk(1'b0, IMM_B, RES_ALU, SRC1_RS1, SRC2_RS2, ALU_SUB, SIZE_WORD, 1'b0, 1'b1, 1'b0),
                   NO_XCPT, 1'b0, 1'b0};
      vecs[14] = '{enc(7'h00, 5'h10, 5'd0, 3'b000, 5'd1, T_JAL), 32'h1038,
                   mk(1'b1, IMM_J, RES_PC4, SRC1_PC, SRC2_IMM, ALU_ADD, SIZE_WORD, 1'b0, 1'b0, 1'b1),
                   NO_XCPT, 1'b0, 1'b0};
      vecs[15] = '{enc(7'h00, 5'd0, 5'd0, 3'b000, 5'd0, T_END), 32'h103C, z, NO_XCPT, 1'b1, 1'b1};
      vecs[16] = '{32'hFFFF_FFFF, 32'h1040, z, UNDEF_INSTR, 1'b1, 1'b1};
      vecs[17] = '{enc(7'h00, 5'd0, 5'd1, 3'b001, 5'd2, T_LOAD), 32'h1044, z, UNDEF_INSTR, 1'b1, 1'b1};
      vecs[18] = '{enc(7'h02, 5'd2, 5'd1, 3'b000, 5'd3, T_OP), 32'h1048, z, UNDEF_INSTR, 1'b1, 1'b1};
      vecs[19] = '{enc(7'h00, 5'd2, 5'd1, 3'b001, 5'd8, T_BR), 32'h104C, z, UNDEF_INSTR, 1'b1, 1'b1};
      vecs[20] = '{enc(7'h00, 5'd3, 5'd1, 3'b001, 5'd4, T_OPI), 32'h1050, z, UNDEF_INSTR, 1'b1, 1'b1};

      reset = 1'b1;  in_valid = 1'b0;  in_instr = '0;  in_pc = '0;  out_ready = 1'b1;
      flush = 1'b0;  wb_valid = '0;    wb_rd = '0;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      #1;
      check("rst_out_valid", 64'(out_valid), 64'd0);
      check("rst_out_ctrl", 64'(out_ctrl), 64'd0);
      check("rst_out_pc", 64'(out_pc), 64'd0);
      check("rst_out_regs", 64'({out_rs1, out_rs2, out_rd}), 64'd0);
      check("rst_out_xcpt", 64'(out_xcpt), 64'(NO_XCPT));
      check("rst_halted", 64'(halted), 64'd0);
      check("rst_in_ready", 64'(in_ready), 64'd1);

      // Decode table: each vector issued from a clean, flushed stage
      for (int i = 0; i < NV; i++) begin
         do_flush();
         in_valid = 1'b1;  in_instr = vecs[i].instr;  in_pc = vecs[i].pc;
         #1 check($sformatf("vec%0d_ready_in", i), 64'(in_ready), 64'd1);
         step();
         in_valid = 1'b0;  in_instr = '0;
         check($sformatf("vec%0d_valid", i), 64'(out_valid), 64'd1);
         check($sformatf("vec%0d_ctrl", i), 64'(out_ctrl), 64'(vecs[i].ctrl));
         check($sformatf("vec%0d_xcpt", i), 64'(out_xcpt), 64'(vecs[i].xcpt));
         check($sformatf("vec%0d_pc", i), 64'(out_pc), 64'(vecs[i].pc));
         check($sformatf("vec%0d_rs1", i), 64'(out_rs1), 64'(vecs[i].instr[19:15]));
         check($sformatf("vec%0d_rs2", i), 64'(out_rs2), 64'(vecs[i].instr[24:20]));
         check($sformatf("vec%0d_rd", i), 64'(out_rd), 64'(vecs[i].instr[11:7]));
         check($sformatf("vec%0d_halted", i), 64'(halted), 64'(vecs[i].halt));
         #1 check($sformatf("vec%0d_ready_after", i), 64'(in_ready), 64'(!vecs[i].busy));
      end

      // RAW stall on x5 released one cycle after its writeback
      do_flush();
      in_valid = 1'b1;  in_instr = enc(7'h00, 5'd1, 5'd0, 3'b000, 5'd5, T_OPI);
      step();
      in_instr = enc(7'h00, 5'd5, 5'd5, 3'b000, 5'd6, T_OP);
      #1 check("raw_stall0", 64'(in_ready), 64'd0);
      step();
      check("raw_stall1", 64'(in_ready), 64'd0);
      wb_valid = 2'b01;  wb_rd[0] = 5'd5;
      #1 check("raw_no_bypass", 64'(in_ready), 64'd0);
      step();
      wb_valid = '0;
      check("raw_release", 64'(in_ready), 64'd1);
      step();
      in_valid = 1'b0;
      check("raw_issued_valid", 64'(out_valid), 64'd1);
      check("raw_issued_rd", 64'(out_rd), 64'd6);

      // MUL blocks issue for MUL_LATENCY=4 cycles; next out_valid on cycle 6
      do_flush();
      in_valid = 1'b1;  in_instr = enc(7'h01, 5'd2, 5'd1, 3'b000, 5'd7, T_OP);
      step();
      in_instr = enc(7'h00, 5'd2, 5'd0, 3'b000, 5'd8, T_OPI);
      for (int k = 1; k <= 4; k++) begin
         check($sformatf("mul_busy_c%0d", k), 64'(in_ready), 64'd0);
         step();
      end
      check("mul_ready_c5", 64'(in_ready), 64'd1);
      check("mul_valid_c5", 64'(out_valid), 64'd0);
      step();
      in_valid = 1'b0;
      check("mul_valid_c6", 64'(out_valid), 64'd1);
      check("mul_next_rd", 64'(out_rd), 64'd8);

      // Undefined instruction halts until flush; flush also clears pending
      do_flush();
      in_valid = 1'b1;  in_instr = enc(7'h00, 5'd1, 5'd0, 3'b000, 5'd5, T_OPI);
      step();
      in_instr = 32'hFFFF_FFFF;
      step();
      check("halt_valid", 64'(out_valid), 64'd1);
      check("halt_xcpt", 64'(out_xcpt), 64'(UNDEF_INSTR));
      check("halt_halted", 64'(halted), 64'd1);
      in_instr = enc(7'h00, 5'd1, 5'd0, 3'b000, 5'd8, T_OPI);
      for (int k = 0; k < 2; k++) begin
         #1 check($sformatf("halt_ready%0d", k), 64'(in_ready), 64'd0);
         step();
         check($sformatf("halt_hold%0d", k), 64'(halted), 64'd1);
      end
      flush = 1'b1;
      #1 check("flush_blocks_issue", 64'(in_ready), 64'd0);
      step();
      flush = 1'b0;
      check("flush_halted", 64'(halted), 64'd0);
      check("flush_valid", 64'(out_valid), 64'd0);
      in_instr = enc(7'h00, 5'd5, 5'd5, 3'b000, 5'd6, T_OP);
      #1 check("flush_pending_clr", 64'(in_ready), 64'd1);
      step();
      in_valid = 1'b0;
      check("flush_next_rd", 64'(out_rd), 64'd6);

      // Backpressure: bundle holds for 3 cycles, next loads once out_ready returns
      do_flush();
      out_ready = 1'b0;
      in_valid = 1'b1;  in_instr = enc(7'h00, 5'd3, 5'd0, 3'b000, 5'd11, T_OPI);  in_pc = 32'h100;
      step();
      in_instr = enc(7'h00, 5'd4, 5'd0, 3'b110, 5'd12, T_OPI);  in_pc = 32'h104;
      for (int k = 0; k < 3; k++) begin
         #1;
         check($sformatf("bp_ready%0d", k), 64'(in_ready), 64'd0);
         check($sformatf("bp_valid%0d", k), 64'(out_valid), 64'd1);
         check($sformatf("bp_pc%0d", k), 64'(out_pc), 64'h100);
         check($sformatf("bp_rd%0d", k), 64'(out_rd), 64'd11);
         step();
      end
      out_ready = 1'b1;
      #1 check("bp_release", 64'(in_ready), 64'd1);
      step();
      in_valid = 1'b0;
      check("bp_next_pc", 64'(out_pc), 64'h104);
      check("bp_next_rd", 64'(out_rd), 64'd12);

      // Issue set beats a same-cycle writeback clear; x0 never becomes pending
      do_flush();
      in_valid = 1'b1;  in_instr = enc(7'h00, 5'd0, 5'd1, 3'b010, 5'd9, T_LOAD);
      wb_valid = 2'b10;  wb_rd[1] = 5'd9;
      step();
      wb_valid = '0;
      in_instr = enc(7'h00, 5'd0, 5'd9, 3'b000, 5'd1, T_OP);
      #1 check("set_wins0", 64'(in_ready), 64'd0);
      step();
      check("set_wins1", 64'(in_ready), 64'd0);
      do_flush();
      in_valid = 1'b1;  in_instr = enc(7'h00, 5'd1, 5'd0, 3'b000, 5'd0, T_OPI);
      step();
      in_instr = enc(7'h00, 5'd0, 5'd0, 3'b000, 5'd1, T_OP);
      #1 check("x0_not_pending", 64'(in_ready), 64'd1);
      step();
      in_valid = 1'b0;

      // Asynchronous reset while MUL_BUSY with x5/x7 pending
      do_flush();
      in_valid = 1'b1;  in_instr = enc(7'h00, 5'd1, 5'd0, 3'b000, 5'd5, T_OPI);
      step();
      in_instr = enc(7'h01, 5'd2, 5'd1, 3'b000, 5'd7, T_OP);
      step();
      in_valid = 1'b0;  out_ready = 1'b0;
      in_instr = enc(7'h00, 5'd7, 5'd5, 3'b000, 5'd6, T_OP);
      #1 check("pre_rst_busy", 64'(in_ready), 64'd0);
      check("pre_rst_valid", 64'(out_valid), 64'd1);
      #1 reset = 1'b1;
      #1;
      check("mid_rst_valid", 64'(out_valid), 64'd0);
      check("mid_rst_halted", 64'(halted), 64'd0);
      check("mid_rst_ready", 64'(in_ready), 64'd1);
      #1 reset = 1'b0;
      out_ready = 1'b1;
      step();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
